// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- command sequencer wrapped around an external multi-cycle ALU.
//
// Accepts (a, b, op) commands on a valid/ready port and buffers them in a small
// FIFO. It issues one command at a time onto the ALU operand/opcode outputs and
// holds them for LAT cycles. It then captures the ALU result and status and
// presents them on a valid/ready result port.
//
// Parameters
//   BITS  : operand / result width (matches the ALU)
//   DEPTH : command FIFO entries, power of two, >= 2
//   LAT   : cycles from the operand-drive edge to the result-sample edge, >= 1
//
// Ports
//   i_clk, i_rst            clock (rising edge), asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready command handshake; i_cmd_a/b/op command payload
//   o_alu_a/b/op            registered operands/opcode to the ALU
//   i_alu_out/i_alu_status  ALU result and status (err, even, ovf, single)
//   o_res_valid/i_res_ready result handshake
//   o_res_data/status/op    captured result, status and producing opcode
//   o_level                 FIFO occupancy
//   i_sticky_clr, o_sticky  sticky error/overflow flags
//
// Optional feature
//   ALU_SEQ_STICKY_EN : when defined, o_sticky accumulates status bit0 (error)
//                       and bit2 (overflow) across captures. When it is
//                       undefined, o_sticky is 0 and i_sticky_clr is ignored.
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int BITS  = 8,
    parameter int DEPTH = 4,
    parameter int LAT   = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,

    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic [BITS-1:0]          i_cmd_a,
    input  logic [BITS-1:0]          i_cmd_b,
    input  logic [1:0]               i_cmd_op,

    output logic [BITS-1:0]          o_alu_a,
    output logic [BITS-1:0]          o_alu_b,
    output logic [1:0]               o_alu_op,
    input  logic [BITS-1:0]          i_alu_out,
    input  logic [3:0]               i_alu_status,

    output logic                     o_res_valid,
    input  logic                     i_res_ready,
    output logic [BITS-1:0]          o_res_data,
    output logic [3:0]               o_res_status,
    output logic [1:0]               o_res_op,

    output logic [$clog2(DEPTH):0]   o_level,

    input  logic                     i_sticky_clr,
    output logic [3:0]               o_sticky
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(LAT + 1);
    localparam int EW = 2 * BITS + 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [EW-1:0]   mem [DEPTH];

    logic [AW-1:0]   wr_ptr_q,    wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q,    rd_ptr_d;
    logic [LW-1:0]   level_q,     level_d;
    logic            cmd_ready_q, cmd_ready_d;

    state_t          state_q,     state_d;
    logic [CW-1:0]   cnt_q,       cnt_d;

    logic [BITS-1:0] alu_a_q,     alu_a_d;
    logic [BITS-1:0] alu_b_q,     alu_b_d;
    logic [1:0]      alu_op_q,    alu_op_d;

    logic            res_valid_q, res_valid_d;
    logic [BITS-1:0] res_data_q,  res_data_d;
    logic [3:0]      res_status_q, res_status_d;
    logic [1:0]      res_op_q,    res_op_d;

    logic            push;
    logic            pop;
    logic            capture;
    logic            fifo_empty;
    logic [EW-1:0]   head;

    // o_cmd_ready is a flop. Reset holds it low. After reset it follows the
    // occupancy that the edge just produced.
    assign push       = i_cmd_valid && cmd_ready_q;
    assign fifo_empty = (level_q == '0);
    assign head       = mem[rd_ptr_q];
    assign capture    = (state_q == ST_WAIT) && (cnt_q == CW'(1));

    // ------------------------------------------------------------------
    // FIFO storage. No reset: emptiness is defined by the pointers/level.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {i_cmd_op, i_cmd_b, i_cmd_a};
        end
    end

    // ------------------------------------------------------------------
    // Sequencer next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pop          = 1'b0;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_status_d = res_status_q;
        res_op_d     = res_op_q;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (capture) begin
                    // The opcode reported with the result is the one still
                    // sitting on the ALU inputs for this command.
                    res_valid_d  = 1'b1;
                    res_data_d   = i_alu_out;
                    res_status_d = i_alu_status;
                    res_op_d     = alu_op_q;
                    state_d      = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (i_res_ready) begin
                    res_valid_d = 1'b0;
                    // Back-to-back issue: the next command goes out on the
                    // same edge that retires the current result.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The ALU inputs change only when a command is popped.
        if (pop) begin
            alu_a_d  = head[BITS-1:0];
            alu_b_d  = head[2*BITS-1:BITS];
            alu_op_d = head[2*BITS+1:2*BITS];
            cnt_d    = CW'(LAT);
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointer / occupancy next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        // The pointers are exactly AW bits wide, so they wrap modulo DEPTH
        // without extra logic.
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        cmd_ready_d = (level_d != LW'(DEPTH));
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            cmd_ready_q  <= 1'b0;
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_status_q <= '0;
            res_op_q     <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            cmd_ready_q  <= cmd_ready_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_status_q <= res_status_d;
            res_op_q     <= res_op_d;
        end
    end

    // ------------------------------------------------------------------
    // Sticky error / overflow flags
    // ------------------------------------------------------------------
`ifdef ALU_SEQ_STICKY_EN
    logic [3:0] sticky_q, sticky_d;
    logic [3:0] sticky_base;

    always_comb begin
        // A clear that coincides with a capture keeps only the new bits.
        sticky_base = i_sticky_clr ? 4'b0000 : sticky_q;
        sticky_d    = sticky_base;
        if (capture) begin
            sticky_d = sticky_base | {1'b0, i_alu_status[2], 1'b0, i_alu_status[0]};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sticky_q <= 4'b0000;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign o_sticky = sticky_q;
`else
    logic unused_sticky_clr;
    assign unused_sticky_clr = i_sticky_clr;
    assign o_sticky          = 4'b0000;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_cmd_ready  = cmd_ready_q;
    assign o_alu_a      = alu_a_q;
    assign o_alu_b      = alu_b_q;
    assign o_alu_op     = alu_op_q;
    assign o_res_valid  = res_valid_q;
    assign o_res_data   = res_data_q;
    assign o_res_status = res_status_q;
    assign o_res_op     = res_op_q;
    assign o_level      = level_q;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq (BITS=8, DEPTH=4, LAT=2).
// It contains a small behavioural ALU fed by the sequencer's registered
// operands. A scoreboard queue is filled when commands are accepted and is
// drained when results are handed over.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_seq;

    localparam int BITS  = 8;
    localparam int DEPTH = 4;
    localparam int LAT   = 2;
    localparam int LW    = $clog2(DEPTH) + 1;

`ifdef ALU_SEQ_STICKY_EN
    localparam bit STICKY_EN = 1'b1;
`else
    localparam bit STICKY_EN = 1'b0;
`endif

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            i_cmd_valid;
    logic            o_cmd_ready;
    logic [BITS-1:0] i_cmd_a;
    logic [BITS-1:0] i_cmd_b;
    logic [1:0]      i_cmd_op;
    logic [BITS-1:0] o_alu_a;
    logic [BITS-1:0] o_alu_b;
    logic [1:0]      o_alu_op;
    logic [BITS-1:0] i_alu_out;
    logic [3:0]      i_alu_status;
    logic            o_res_valid;
    logic            i_res_ready;
    logic [BITS-1:0] o_res_data;
    logic [3:0]      o_res_status;
    logic [1:0]      o_res_op;
    logic [LW-1:0]   o_level;
    logic            i_sticky_clr;
    logic [3:0]      o_sticky;

    always #5 i_clk = ~i_clk;

    alu_seq #(.BITS(BITS), .DEPTH(DEPTH), .LAT(LAT)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_cmd_valid  (i_cmd_valid),
        .o_cmd_ready  (o_cmd_ready),
        .i_cmd_a      (i_cmd_a),
        .i_cmd_b      (i_cmd_b),
        .i_cmd_op     (i_cmd_op),
        .o_alu_a      (o_alu_a),
        .o_alu_b      (o_alu_b),
        .o_alu_op     (o_alu_op),
        .i_alu_out    (i_alu_out),
        .i_alu_status (i_alu_status),
        .o_res_valid  (o_res_valid),
        .i_res_ready  (i_res_ready),
        .o_res_data   (o_res_data),
        .o_res_status (o_res_status),
        .o_res_op     (o_res_op),
        .o_level      (o_level),
        .i_sticky_clr (i_sticky_clr),
        .o_sticky     (o_sticky)
    );

    // ------------------------------------------------------------------
    // Reference ALU: returns {status, result}; status = {single, ovf, even, err}
    // ------------------------------------------------------------------
    function automatic logic [11:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] op);
        logic [7:0] r;
        logic [3:0] s;
        r = 8'h00;
        s = 4'b0000;
        case (op)
            2'b00: begin
                r    = a - b;
                s[2] = (a < b);
            end
            2'b01: r = (a > b) ? 8'h01 : ((a == b) ? 8'h00 : 8'hFF);
            2'b10: begin
                r    = a << b[2:0];
                s[0] = (b > 8'd7);
            end
            default: r = a ^ (8'h01 << b[2:0]);
        endcase
        s[1] = ~r[0];
        s[3] = $onehot(r);
        return {s, r};
    endfunction

    // The sequencer's operand flops are the first stage. The bench adds the
    // remaining LAT-1 stages, so the result reaches the ALU outputs by the
    // sample edge.
    logic [11:0] alu_pipe [LAT-1];
    always @(posedge i_clk) begin
        alu_pipe[0] <= alu_f(o_alu_a, o_alu_b, o_alu_op);
        for (int i = 1; i < LAT - 1; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign i_alu_out    = alu_pipe[LAT-2][7:0];
    assign i_alu_status = alu_pipe[LAT-2][11:8];

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    logic [13:0] sb_q [$];     // {op, status, data}
    int          cyc = 0;
    int          last_acc = -1;
    bit          spacing_en = 1'b0;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Result monitor: a handshake is seen at the negedge before the accepting edge.
    initial begin
        logic [13:0] exp_e;
        forever begin
            @(negedge i_clk);
            if (i_rst === 1'b1 && o_res_valid && i_res_ready) begin
                $display("result  op=%0d data=0x%02h status=0x%0h cyc=%0d",
                         o_res_op, o_res_data, o_res_status, cyc);
                if (sb_q.size() == 0) begin
                    check_val("spurious_result", 32'd1, 32'd0);
                end else begin
                    exp_e = sb_q.pop_front();
                    check_val("res_data",   32'(o_res_data),   32'(exp_e[7:0]));
                    check_val("res_status", 32'(o_res_status), 32'(exp_e[11:8]));
                    check_val("res_op",     32'(o_res_op),     32'(exp_e[13:12]));
                end
                if (spacing_en && last_acc >= 0)
                    check_val("res_spacing", 32'(cyc - last_acc), 32'(LAT + 1));
                last_acc = cyc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 ns after the rising edge)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        bit ok;
        bit done;
        done        = 1'b0;
        i_cmd_valid = 1'b1;
        i_cmd_a     = a;
        i_cmd_b     = b;
        i_cmd_op    = op;
        for (int k = 0; k < 100 && !done; k++) begin
            ok = o_cmd_ready;
            tick();
            if (ok) done = 1'b1;
        end
        i_cmd_valid = 1'b0;
        if (done) begin
            sb_q.push_back({op, alu_f(a, b, op)});
            $display("command a=0x%02h b=0x%02h op=%0d cyc=%0d", a, b, op, cyc);
        end else begin
            check_val("push_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while ((sb_q.size() != 0 || o_res_valid) && k < budget) begin
            tick();
            k++;
        end
        check_val("drain", 32'(sb_q.size()), 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int exp_lv [5];
        int k;
        exp_lv = '{1, 1, 2, 3, 4};

        i_rst        = 1'b0;
        i_cmd_valid  = 1'b0;
        i_cmd_a      = '0;
        i_cmd_b      = '0;
        i_cmd_op     = '0;
        i_res_ready  = 1'b0;
        i_sticky_clr = 1'b0;

        // Reset state
        tick();
        tick();
        check_val("rst_cmd_ready", 32'(o_cmd_ready), 32'd0);
        check_val("rst_level",     32'(o_level),     32'd0);
        check_val("rst_res_valid", 32'(o_res_valid), 32'd0);
        check_val("rst_alu_a",     32'(o_alu_a),     32'd0);
        check_val("rst_res_data",  32'(o_res_data),  32'd0);
        check_val("rst_sticky",    32'(o_sticky),    32'd0);
        i_rst = 1'b1;
        tick();
        check_val("ready_after_rst", 32'(o_cmd_ready), 32'd1);

        // 1. Single command latency: accepted at edge 0.
        i_cmd_valid = 1'b1;
        i_cmd_a     = 8'h05;
        i_cmd_b     = 8'h03;
        i_cmd_op    = 2'b00;
        tick();                                   // edge 0
        i_cmd_valid = 1'b0;
        sb_q.push_back({2'b00, alu_f(8'h05, 8'h03, 2'b00)});
        $display("command a=0x05 b=0x03 op=0 cyc=%0d", cyc);
        check_val("t1_level_e0", 32'(o_level), 32'd1);
        tick();                                   // edge 1
        check_val("t1_alu_a",    32'(o_alu_a),  32'h05);
        check_val("t1_alu_b",    32'(o_alu_b),  32'h03);
        check_val("t1_alu_op",   32'(o_alu_op), 32'd0);
        check_val("t1_level_e1", 32'(o_level),  32'd0);
        tick();                                   // edge 2
        check_val("t1_valid_e2", 32'(o_res_valid), 32'd0);
        tick();                                   // edge 3
        check_val("t1_valid_e3", 32'(o_res_valid), 32'd1);
        check_val("t1_data",     32'(o_res_data),  32'h02);
        check_val("t1_op",       32'(o_res_op),    32'd0);
        i_res_ready = 1'b1;
        tick();                                   // edge 4: result retired
        check_val("t1_valid_e4", 32'(o_res_valid), 32'd0);
        i_res_ready = 1'b0;

        // 2. Fill the FIFO while the consumer stalls.
        for (int i = 0; i < 5; i++) begin
            push_cmd(8'h10 + 8'(i), 8'h01 + 8'(i), 2'(i));
            check_val("t2_level", 32'(o_level), 32'(exp_lv[i]));
        end
        check_val("t2_ready_full", 32'(o_cmd_ready), 32'd0);
        i_cmd_valid = 1'b1;
        i_cmd_a     = 8'h7E;
        i_cmd_b     = 8'h04;
        i_cmd_op    = 2'b11;
        repeat (4) tick();
        check_val("t2_stall_level", 32'(o_level),     32'd4);
        check_val("t2_stall_ready", 32'(o_cmd_ready), 32'd0);

        // 3. Drain with ready held high; the stalled 6th command goes in as space frees.
        last_acc    = -1;
        spacing_en  = 1'b1;
        i_res_ready = 1'b1;
        push_cmd(8'h7E, 8'h04, 2'b11);
        wait_drain(200);
        spacing_en  = 1'b0;
        i_res_ready = 1'b0;

        // 4. Long HOLD: outputs stable, no pop.
        push_cmd(8'h21, 8'h02, 2'b10);
        push_cmd(8'h33, 8'h33, 2'b01);
        k = 0;
        while (!o_res_valid && k < 20) begin
            tick();
            k++;
        end
        check_val("t4_valid", 32'(o_res_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("t4_hold_valid", 32'(o_res_valid), 32'd1);
            check_val("t4_hold_data",  32'(o_res_data),  32'(alu_f(8'h21, 8'h02, 2'b10) & 12'h0FF));
            check_val("t4_hold_op",    32'(o_res_op),    32'd2);
            check_val("t4_hold_alu_a", 32'(o_alu_a),     32'h21);
            check_val("t4_hold_level", 32'(o_level),     32'd1);
        end
        i_res_ready = 1'b1;
        wait_drain(100);
        i_res_ready = 1'b0;

        // 5. Reset in the middle of WAIT with two entries queued.
        push_cmd(8'h44, 8'h11, 2'b00);
        push_cmd(8'h55, 8'h05, 2'b10);
        push_cmd(8'h66, 8'h02, 2'b11);
        check_val("t5_level_pre", 32'(o_level), 32'd2);
        i_rst = 1'b0;
        #1;
        check_val("t5_level",     32'(o_level),     32'd0);
        check_val("t5_cmd_ready", 32'(o_cmd_ready), 32'd0);
        check_val("t5_alu_a",     32'(o_alu_a),     32'd0);
        check_val("t5_alu_b",     32'(o_alu_b),     32'd0);
        check_val("t5_res_valid", 32'(o_res_valid), 32'd0);
        check_val("t5_res_data",  32'(o_res_data),  32'd0);
        sb_q.delete();
        tick();
        tick();
        i_rst       = 1'b1;
        i_res_ready = 1'b1;
        tick();
        check_val("t5_ready_rel", 32'(o_cmd_ready), 32'd1);
        for (int i = 0; i < 12; i++) begin
            tick();
            check_val("t5_no_stale", 32'(o_res_valid), 32'd0);
        end
        check_val("t5_level_post", 32'(o_level), 32'd0);

        // 6. Sticky flags (expected values follow the build configuration).
        push_cmd(8'h01, 8'h09, 2'b10);            // status bit0
        repeat (4) tick();
        check_val("t6_sticky_err", 32'(o_sticky), STICKY_EN ? 32'h1 : 32'h0);
        push_cmd(8'h03, 8'h05, 2'b00);            // status bit2
        repeat (4) tick();
        check_val("t6_sticky_both", 32'(o_sticky), STICKY_EN ? 32'h5 : 32'h0);
        // Clear coinciding with a capture keeps only that capture's bits.
        push_cmd(8'h01, 8'h09, 2'b10);            // accepted at edge N
        tick();                                   // N+1
        tick();                                   // N+2
        i_sticky_clr = 1'b1;
        tick();                                   // N+3 capture
        i_sticky_clr = 1'b0;
        check_val("t6_clr_capture", 32'(o_sticky), STICKY_EN ? 32'h1 : 32'h0);
        push_cmd(8'h05, 8'h03, 2'b00);            // status bits 0/2 clear
        tick();
        tick();
        i_sticky_clr = 1'b1;
        tick();
        i_sticky_clr = 1'b0;
        check_val("t6_clr_zero", 32'(o_sticky), 32'h0);
        push_cmd(8'h02, 8'h06, 2'b00);            // overflow, no clear
        repeat (4) tick();
        check_val("t6_sticky_ovf", 32'(o_sticky), STICKY_EN ? 32'h4 : 32'h0);
        i_sticky_clr = 1'b1;                      // clear without capture
        tick();
        i_sticky_clr = 1'b0;
        check_val("t6_clr_idle", 32'(o_sticky), 32'h0);
        wait_drain(50);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks so far %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
